// File: rtl/alarm_sequencer_if.sv
// rtl/alarm_sequencer_if.sv - alarm configuration handshake between set-time UI and sequencer
interface alarm_sequencer_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [5:0] cfg_hours;
   logic [5:0] cfg_minutes;
   logic       cfg_enable;
   logic       cfg_err;

   modport master (
      output cfg_valid,
      output cfg_hours,
      output cfg_minutes,
      output cfg_enable,
      input  cfg_ready,
      input  cfg_err
   );

   modport slave (
      input  cfg_valid,
      input  cfg_hours,
      input  cfg_minutes,
      input  cfg_enable,
      output cfg_ready,
      output cfg_err
   );
endinterface

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm arm/ring/snooze sequencer driving status LEDs
// Every output is a register updated alongside the state transition that causes it.
module alarm_sequencer #(
   parameter int RING_SECONDS   = 10,
   parameter int SNOOZE_MINUTES = 5,
   parameter int MAX_SNOOZES    = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick_1hz,
   input  logic [5:0]       cur_hours,
   input  logic [5:0]       cur_minutes,
   input  logic [5:0]       cur_seconds,
   alarm_sequencer_if.slave cfg,
   input  logic             snooze_btn,
   input  logic             stop_btn,
   output logic [2:0]       led,
   output logic             alarm_active,
   output logic [1:0]       state,
   output logic [1:0]       snooze_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_RINGING = 2'd2,
      ST_SNOOZE  = 2'd3
   } state_t;

   localparam logic [2:0] LED_IDLE   = 3'b110;
   localparam logic [2:0] LED_ARMED  = 3'b100;
   localparam logic [2:0] LED_RING   = 3'b011;
   localparam logic [2:0] LED_SNOOZE = 3'b101;
   localparam logic [5:0] RING_LAST  = 6'(RING_SECONDS - 1);
   localparam logic [6:0] SNZ_ADD    = 7'(SNOOZE_MINUTES);
   localparam logic [1:0] SNZ_MAX    = 2'(MAX_SNOOZES);

   state_t     r_state;
   logic [5:0] r_tgt_h;
   logic [5:0] r_tgt_m;
   logic [5:0] r_snz_h;
   logic [5:0] r_snz_m;
   logic [5:0] r_ring_cnt;
   logic [1:0] r_snooze_count;
   logic [2:0] r_led;
   logic       r_active;
   logic       r_cfg_ready;
   logic       r_cfg_err;

   logic       w_cfg_xfer;
   logic       w_cfg_bad;
   logic       w_minute_tick;
   logic       w_alarm_hit;
   logic       w_snz_hit;
   logic       w_ring_done;
   logic       w_can_snooze;
   logic       w_snz_carry;
   logic [6:0] w_snz_sum;
   logic [5:0] w_snz_m;
   logic [5:0] w_snz_h;

   assign w_cfg_xfer    = cfg.cfg_valid && r_cfg_ready;
   assign w_cfg_bad     = (cfg.cfg_hours > 6'd23) || (cfg.cfg_minutes > 6'd59);
   assign w_minute_tick = tick_1hz && (cur_seconds == 6'd0);
   assign w_alarm_hit   = w_minute_tick && (cur_hours == r_tgt_h) && (cur_minutes == r_tgt_m);
   assign w_snz_hit     = w_minute_tick && (cur_hours == r_snz_h) && (cur_minutes == r_snz_m);
   assign w_ring_done   = (r_ring_cnt == RING_LAST);
   assign w_can_snooze  = (r_snooze_count < SNZ_MAX);

   // Snooze wake-up time rolls over the hour and past midnight.
   assign w_snz_sum   = {1'b0, cur_minutes} + SNZ_ADD;
   assign w_snz_carry = (w_snz_sum >= 7'd60);
   assign w_snz_m     = w_snz_carry ? 6'(w_snz_sum - 7'd60) : w_snz_sum[5:0];
   assign w_snz_h     = !w_snz_carry ? cur_hours :
                        (cur_hours == 6'd23) ? 6'd0 : cur_hours + 6'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_tgt_h        <= 6'd0;
         r_tgt_m        <= 6'd0;
         r_snz_h        <= 6'd0;
         r_snz_m        <= 6'd0;
         r_ring_cnt     <= 6'd0;
         r_snooze_count <= 2'd0;
         r_led          <= LED_IDLE;
         r_active       <= 1'b0;
         r_cfg_ready    <= 1'b1;
         r_cfg_err      <= 1'b0;
      end else begin
         r_cfg_err <= 1'b0;
         case (r_state)
            ST_IDLE, ST_ARMED: begin
               // A config transfer takes precedence over a coincident alarm match.
               if (w_cfg_xfer) begin
                  if (w_cfg_bad) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_tgt_h <= cfg.cfg_hours;
                     r_tgt_m <= cfg.cfg_minutes;
                     if (cfg.cfg_enable) begin
                        r_state <= ST_ARMED;
                        r_led   <= LED_ARMED;
                     end else begin
                        r_state <= ST_IDLE;
                        r_led   <= LED_IDLE;
                     end
                  end
               end else if ((r_state == ST_ARMED) && w_alarm_hit) begin
                  r_state        <= ST_RINGING;
                  r_led          <= LED_RING;
                  r_active       <= 1'b1;
                  r_cfg_ready    <= 1'b0;
                  r_ring_cnt     <= 6'd0;
                  r_snooze_count <= 2'd0;
               end
            end
            ST_RINGING: begin
               if (stop_btn || (tick_1hz && w_ring_done && !(snooze_btn && w_can_snooze))) begin
                  r_state        <= ST_ARMED;
                  r_led          <= LED_ARMED;
                  r_active       <= 1'b0;
                  r_cfg_ready    <= 1'b1;
                  r_snooze_count <= 2'd0;
               end else if (snooze_btn && w_can_snooze) begin
                  r_state        <= ST_SNOOZE;
                  r_led          <= LED_SNOOZE;
                  r_active       <= 1'b0;
                  r_snooze_count <= r_snooze_count + 2'd1;
                  r_snz_h        <= w_snz_h;
                  r_snz_m        <= w_snz_m;
               end else if (tick_1hz) begin
                  r_ring_cnt <= r_ring_cnt + 6'd1;
                  r_led      <= r_led ^ 3'b100;
               end
            end
            ST_SNOOZE: begin
               if (stop_btn) begin
                  r_state        <= ST_ARMED;
                  r_led          <= LED_ARMED;
                  r_cfg_ready    <= 1'b1;
                  r_snooze_count <= 2'd0;
               end else if (w_snz_hit) begin
                  r_state    <= ST_RINGING;
                  r_led      <= LED_RING;
                  r_active   <= 1'b1;
                  r_ring_cnt <= 6'd0;
               end
            end
         endcase
      end
   end

   assign cfg.cfg_ready = r_cfg_ready;
   assign cfg.cfg_err   = r_cfg_err;
   assign led           = r_led;
   assign alarm_active  = r_active;
   assign state         = r_state;
   assign snooze_count  = r_snooze_count;

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
Control FSM that sequences the alarm function of the alarm clock. It holds the programmed alarm time, compares it against the running timekeeper (hours/minutes/seconds plus a 1 Hz tick) and walks the alarm through armed, ringing and snooze phases. It drives the status LEDs. A valid/ready port loads the configuration from the set-time UI logic.

Parameters:
RING_SECONDS, 10, ticks the alarm rings before auto-stop (1..63)
SNOOZE_MINUTES, 5, snooze delay in minutes (1..59)
MAX_SNOOZES, 3, snoozes allowed per alarm event (0..3)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_1hz  in  1  one-cycle pulse, once per second, from timekeeper
cur_hours  in  6  current hours 0-23, stable on tick cycle
cur_minutes  in  6  current minutes 0-59
cur_seconds  in  6  current seconds 0-59
cfg_valid  in  1  configuration request
cfg_ready  out  1  configuration can be accepted
cfg_hours  in  6  alarm hours
cfg_minutes  in  6  alarm minutes
cfg_enable  in  1  1 = arm alarm, 0 = disarm
cfg_err  out  1  one-cycle pulse: out-of-range config rejected
snooze_btn  in  1  one-cycle debounced pulse
stop_btn  in  1  one-cycle debounced pulse
led  out  3  status LEDs
alarm_active  out  1  high while RINGING
state  out  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3
snooze_count  out  2  snoozes used in current event

Behaviour:
- Reset: state IDLE; led 3'b110; alarm_active 0; cfg_ready 1; cfg_err 0; snooze_count 0; alarm/snooze targets 0; ring counter 0. Reset mid-RINGING or mid-SNOOZE returns to IDLE on the next edge.
- All outputs are registered. state, led and alarm_active change on the clock edge after the causing event.
- Config handshake:
  - cfg_ready = 1 in IDLE and ARMED, 0 in RINGING and SNOOZE.
  - A transfer occurs when cfg_valid && cfg_ready.
  - If cfg_hours>23 or cfg_minutes>59: cfg_err pulses 1 cycle, targets and state are unchanged.
  - Otherwise the target is loaded and the next state is ARMED (cfg_enable=1) or IDLE (cfg_enable=0).
- ARMED: on tick_1hz with cur_hours==target_h, cur_minutes==target_m, cur_seconds==0, go to RINGING, clear ring counter, clear snooze_count.
  - A config transfer in the same cycle as the match wins; no ring occurs that second.
- RINGING: each tick_1hz increments the ring counter. Priority is stop > snooze > timeout.
  - stop_btn: go to ARMED, snooze_count cleared.
  - snooze_btn with snooze_count<MAX_SNOOZES: go to SNOOZE and snooze_count++.
    - Snooze target minute = cur_minutes+SNOOZE_MINUTES (7-bit add); if >=60, subtract 60 and hour+1, with 23 wrapping to 0.
    - Snooze target second is 0.
  - snooze_btn with snooze_count==MAX_SNOOZES: ignored.
  - Timeout: on the tick where the ring counter equals RING_SECONDS-1, go to ARMED and clear snooze_count.
- SNOOZE:
  - A tick matching the snooze target (h, m, s=0) returns to RINGING with the ring counter cleared; snooze_count is kept.
  - stop_btn returns to ARMED and clears snooze_count.
- The armed alarm re-fires daily; the target persists until reconfigured.
- led:
  - IDLE 3'b110.
  - ARMED 3'b100.
  - RINGING alternates 3'b011 / 3'b111, toggling on each tick, starting at 3'b011.
  - SNOOZE 3'b101.
- alarm_active = (state==RINGING).
- Buttons in IDLE/ARMED are ignored.

Test Plan:
- Reset, then cfg 07:30 enable=1 → cfg_ready handshake in one cycle; state=1; led=3'b100; no cfg_err.
- Armed at 07:30, tick with time 07:30:00 → state=2, alarm_active=1, led=3'b011, toggling per tick; no stop → after 10 ticks state=1, led=3'b100.
- Ringing at 23:58, snooze_btn → state=3, snooze_count=1; tick at 00:03:00 → state=2 (hour wrap); stop_btn → state=1, snooze_count=0.
- Snooze three times (MAX=3), fourth snooze_btn → stays RINGING, snooze_count=3; stop_btn and snooze_btn in the same cycle → ARMED.
- cfg 24:10 or 12:60 → cfg_err one-cycle pulse, target unchanged; cfg_valid during RINGING → cfg_ready=0, no transfer; cfg enable=0 → IDLE, no ring at target.
- Reset asserted mid-RINGING → next cycle state=0, led=3'b110, alarm_active=0, snooze_count=0; match-tick coincident with cfg transfer → no ring.
